// File: rtl/me_search_ctrl_if.sv
// Handshake and decode bundle between the motion-estimation sequencer and its
// PE array / comparator / memories. The sequencer connects through the slave modport.
interface me_search_ctrl_if #(
  parameter int LOGN = 4,
  parameter int VPOS = 16
);
  localparam int N    = 1 << LOGN;
  localparam int LOGV = $clog2(VPOS);
  localparam int AW_R = 2 * LOGN;
  localparam int AW_S = $clog2((VPOS + N) * 2 * N);

  logic            start;
  logic            stall;
  logic            busy;
  logic            done;
  logic [N-1:0]    s1s2_mux;
  logic [N-1:0]    new_dist;
  logic [LOGN:0]   pe_ready;
  logic            comp_start;
  logic            blk_last;
  logic [LOGN-1:0] vec_x;
  logic [LOGV-1:0] vec_y;
  logic [AW_R-1:0] addr_r;
  logic [AW_S-1:0] addr_s1;
  logic [AW_S-1:0] addr_s2;

  modport master (
    output start, stall,
    input  busy, done, s1s2_mux, new_dist, pe_ready, comp_start, blk_last,
           vec_x, vec_y, addr_r, addr_s1, addr_s2
  );

  modport slave (
    input  start, stall,
    output busy, done, s1s2_mux, new_dist, pe_ready, comp_start, blk_last,
           vec_x, vec_y, addr_r, addr_s1, addr_s2
  );
endinterface

// File: rtl/me_search_ctrl.sv
// Full-search block-matching sequencer: one counter walks every (candidate, pixel) pair;
// all addresses, PE strobes and motion vectors are pure decodes of state and count.
module me_search_ctrl #(
  parameter int LOGN = 4,
  parameter int VPOS = 16
) (
  input logic             clock,
  input logic             reset_n,
  me_search_ctrl_if.slave bus
);
  localparam int N    = 1 << LOGN;
  localparam int LOGV = $clog2(VPOS);
  localparam int CW   = 2 * LOGN + LOGV + 1;
  localparam int AW_S = $clog2((VPOS + N) * 2 * N);
  localparam logic [CW-1:0] LAST = CW'(N * N * VPOS + N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: reset is sampled on the clock edge here, so it belongs inside the clocked
  // branch rather than in the sensitivity list; all state updates use <=.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: if (!bus.stall) begin
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + CW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [LOGN-1:0]   col, row, t_col, t_row;
  logic [LOGV-1:0]   vr, t_vr;
  logic [2*LOGN-1:0] lo;
  logic [CW-2:0]     t;
  logic              comp;

  assign col  = cnt_q[LOGN-1:0];
  assign row  = cnt_q[2*LOGN-1:LOGN];
  assign vr   = cnt_q[CW-2:2*LOGN];
  assign lo   = cnt_q[2*LOGN-1:0];
  assign comp = (cnt_q >= CW'(N * N));

  // Port-2 stream lags port 1 by N cycles; the dropped MSB never matters once cnt >= N.
  assign t     = cnt_q[CW-2:0] - (CW-1)'(N);
  assign t_col = t[LOGN-1:0];
  assign t_row = t[2*LOGN-1:LOGN];
  assign t_vr  = t[CW-2:2*LOGN];

  always_comb begin
    bus.busy       = 1'b0;
    bus.done       = (state_q == DONE);
    bus.s1s2_mux   = '0;
    bus.new_dist   = '0;
    bus.pe_ready   = '0;
    bus.comp_start = 1'b0;
    bus.blk_last   = 1'b0;
    bus.vec_x      = '0;
    bus.vec_y      = '0;
    bus.addr_r     = '0;
    bus.addr_s1    = '0;
    bus.addr_s2    = '0;
    if (state_q == RUN) begin
      bus.busy       = 1'b1;
      bus.comp_start = comp;
      bus.blk_last   = (lo == {2 * LOGN{1'b1}});
      bus.vec_x      = col - LOGN'(N / 2);
      bus.vec_y      = vr - LOGV'(VPOS / 2);
      bus.addr_r     = lo;
      bus.addr_s1    = (AW_S'(vr) + AW_S'(row)) * AW_S'(2 * N) + AW_S'(col);
      if (cnt_q >= CW'(N))
        bus.addr_s2  = (AW_S'(t_vr) + AW_S'(t_row)) * AW_S'(2 * N) + AW_S'(t_col) + AW_S'(N);
      for (int i = 0; i < N; i++) begin
        bus.new_dist[i] = (lo == (2 * LOGN)'(i));
        bus.s1s2_mux[i] = (col >= LOGN'(i));
        if (bus.new_dist[i] && comp) bus.pe_ready = (LOGN + 1)'(i + 1);
      end
    end
  end
endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl at N=16, VPOS=16 (LAST=4111); expected values are
// hand-derived from the counter field decodes.
module tb_me_search_ctrl;
  logic clock = 1'b0;
  logic reset_n;

  me_search_ctrl_if #(.LOGN(4), .VPOS(16)) bus ();
  me_search_ctrl #(.LOGN(4), .VPOS(16)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;
  int n_busy  = 0;
  int n_done  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled on the falling edge; inputs change right after it.
  task automatic tick();
    @(negedge clock);
    if (bus.busy) n_busy++;
    if (bus.done) n_done++;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},    32'(bus.busy),     32'h0);
    check({tag, ".addr_r"},  32'(bus.addr_r),   32'h0);
    check({tag, ".addr_s1"}, 32'(bus.addr_s1),  32'h0);
    check({tag, ".addr_s2"}, 32'(bus.addr_s2),  32'h0);
    check({tag, ".nd"},      32'(bus.new_dist), 32'h0);
    check({tag, ".mux"},     32'(bus.s1s2_mux), 32'h0);
    check({tag, ".vec_x"},   32'(bus.vec_x),    32'h0);
    check({tag, ".vec_y"},   32'(bus.vec_y),    32'h0);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("rst.done", 32'(bus.done), 32'h0);
    check_quiet("rst");

    // Run 1: spot decodes, mid-run stall, ignored start, stall on LAST
    n_busy = 0; n_done = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("c0.busy",    32'(bus.busy),       32'h1);
    check("c0.addr_r",  32'(bus.addr_r),     32'h0);
    check("c0.addr_s1", 32'(bus.addr_s1),    32'h0);
    check("c0.addr_s2", 32'(bus.addr_s2),    32'h0);
    check("c0.nd",      32'(bus.new_dist),   32'h0001);
    check("c0.mux",     32'(bus.s1s2_mux),   32'h0001);
    check("c0.pe_rdy",  32'(bus.pe_ready),   32'h0);
    check("c0.comp",    32'(bus.comp_start), 32'h0);
    check("c0.vec_x",   32'(bus.vec_x),      32'h8);
    check("c0.vec_y",   32'(bus.vec_y),      32'h8);

    repeat (15) tick();
    check("c15.nd",      32'(bus.new_dist), 32'h8000);
    check("c15.mux",     32'(bus.s1s2_mux), 32'hFFFF);
    check("c15.vec_x",   32'(bus.vec_x),    32'h7);
    check("c15.addr_s2", 32'(bus.addr_s2),  32'h0);
    tick();
    check("c16.nd",      32'(bus.new_dist), 32'h0);
    check("c16.addr_s1", 32'(bus.addr_s1),  32'd32);
    check("c16.addr_s2", 32'(bus.addr_s2),  32'd16);

    repeat (239) tick();
    check("c255.blk",     32'(bus.blk_last),   32'h1);
    check("c255.addr_s1", 32'(bus.addr_s1),    32'd495);
    check("c255.pe_rdy",  32'(bus.pe_ready),   32'h0);
    check("c255.comp",    32'(bus.comp_start), 32'h0);
    tick();
    check("c256.comp",    32'(bus.comp_start), 32'h1);
    check("c256.pe_rdy",  32'(bus.pe_ready),   32'h1);
    check("c256.addr_s1", 32'(bus.addr_s1),    32'd32);
    check("c256.vec_y",   32'(bus.vec_y),      32'h9);
    check("c256.blk",     32'(bus.blk_last),   32'h0);
    repeat (15) tick();
    check("c271.pe_rdy",  32'(bus.pe_ready),   32'd16);
    check("c271.addr_s2", 32'(bus.addr_s2),    32'd511);
    tick();
    check("c272.addr_s2", 32'(bus.addr_s2),    32'd48);
    check("c272.pe_rdy",  32'(bus.pe_ready),   32'h0);

    repeat (28) tick();
    check("c300.addr_r",  32'(bus.addr_r),  32'd44);
    check("c300.addr_s1", 32'(bus.addr_s1), 32'd108);
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall.addr_r",  32'(bus.addr_r),  32'd44);
      check("stall.addr_s1", 32'(bus.addr_s1), 32'd108);
    end
    bus.stall = 1'b0;
    tick();
    check("c301.addr_r", 32'(bus.addr_r), 32'd45);

    repeat (699) tick();
    check("c1000.addr_r", 32'(bus.addr_r), 32'd232);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("c1001.busy",    32'(bus.busy),    32'h1);
    check("c1001.addr_r",  32'(bus.addr_r),  32'd233);
    check("c1001.addr_s1", 32'(bus.addr_s1), 32'd553);
    check("c1001.vec_y",   32'(bus.vec_y),   32'hB);

    repeat (3110) tick();
    check("last.busy",   32'(bus.busy),   32'h1);
    check("last.addr_r", 32'(bus.addr_r), 32'd15);
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lstall.busy", 32'(bus.busy), 32'h1);
      check("lstall.done", 32'(bus.done), 32'h0);
    end
    bus.stall = 1'b0;
    tick();
    check("done1.done", 32'(bus.done), 32'h1);
    check_quiet("done1");
    tick();
    check("idle1.done", 32'(bus.done), 32'h0);
    check_quiet("idle1");
    repeat (5) tick();
    check("run1.busy_cycles", 32'(n_busy), 32'd4120);
    check("run1.done_count",  32'(n_done), 32'd1);

    // Run 2: reset mid-scan abandons it without a done pulse
    n_busy = 0; n_done = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (2000) tick();
    check("c2000.addr_r", 32'(bus.addr_r), 32'd208);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mrst.done", 32'(bus.done), 32'h0);
    check_quiet("mrst");
    repeat (4) tick();
    check("mrst.done_count", 32'(n_done), 32'd0);

    // Run 3: start together with stall in IDLE starts; clean run of 4112 busy cycles
    n_busy = 0; n_done = 0;
    bus.start = 1'b1;
    bus.stall = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check("run3.busy",   32'(bus.busy),   32'h1);
    check("run3.addr_r", 32'(bus.addr_r), 32'h0);
    begin
      int guard = 0;
      while (bus.busy && guard < 5000) begin
        tick();
        guard++;
      end
      check("run3.timeout", 32'(guard < 5000), 32'h1);
    end
    check("run3.done",        32'(bus.done), 32'h1);
    check("run3.busy_cycles", 32'(n_busy),   32'd4112);
    tick();
    check("run3.done_off", 32'(bus.done), 32'h0);
    check_quiet("idle3");
    repeat (3) tick();
    check("run3.done_count", 32'(n_done), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
